muller_c_join_pipe: RTL and testbench

// - Parametrised successor to the single 2-input Muller C-element project:
//   a clocked, two-phase (transition-signalled) Sutherland micropipeline.
// - Front stage is a generalised C-element joining NCHAN request channels;

---
 rtl/muller_c_join_pipe_if.sv | 33 +++
 rtl/muller_c_join_pipe.sv | 106 ++++++++++
 tb/tb_muller_c_join_pipe.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muller_c_join_pipe_if.sv
// Two-phase request/acknowledge bundle for muller_c_join_pipe.
// The master is the environment (producer and consumer); the slave is the pipeline.
interface muller_c_join_pipe_if #(
  parameter int NCHAN = 2,
  parameter int WIDTH = 4
);
  localparam int DW = NCHAN * WIDTH;

  logic [NCHAN-1:0] in_req;
  logic [DW-1:0]    in_data;
  logic             in_ack;
  logic             out_req;
  logic [DW-1:0]    out_data;
  logic             out_ack;

  modport master (
    output in_req,
    output in_data,
    output out_ack,
    input  in_ack,
    input  out_req,
    input  out_data
  );

  modport slave (
    input  in_req,
    input  in_data,
    input  out_ack,
    output in_ack,
    output out_req,
    output out_data
  );
endinterface

// File: rtl/muller_c_join_pipe.sv
// Clocked two-phase Sutherland micropipeline with an NCHAN-way C-element join in front.
// Define MULLER_C_PERF_EN to add the occ (tokens held) and tok_cnt (tokens delivered) ports.
module muller_c_join_pipe #(
  parameter int NCHAN = 2,
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  muller_c_join_pipe_if.slave        bus
`ifdef MULLER_C_PERF_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ,
  output logic [15:0]                tok_cnt
`endif
);
  localparam int DW = NCHAN * WIDTH;

  logic [DEPTH-1:0] c;
  logic [DEPTH-1:0] r;
  logic [DEPTH-1:0] a;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] fire;
  logic [DW-1:0]    d   [DEPTH];
  logic [DW-1:0]    din [DEPTH];
  logic             join_ok;

  // Channels only agree once the slowest one has toggled: that is the join.
  assign join_ok = (&bus.in_req) | ~(|bus.in_req);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign r[i]   = bus.in_req[0];
      assign v[i]   = join_ok;
      assign din[i] = bus.in_data;
    end else begin : g_body
      assign r[i]   = c[i-1];
      assign v[i]   = 1'b1;
      assign din[i] = d[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign a[i] = bus.out_ack;
    end else begin : g_link
      assign a[i] = c[i+1];
    end

    assign fire[i] = v[i] & (r[i] ^ a[i]) & (r[i] ^ c[i]);
  end

  // Every stage decides from pre-edge values, so a token advances one stage per edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      c <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fire[i]) begin
          c[i] <= r[i];
          d[i] <= din[i];
        end
      end
    end
  end

  assign bus.in_ack   = c[0];
  assign bus.out_req  = c[DEPTH-1];
  assign bus.out_data = d[DEPTH-1];

`ifdef MULLER_C_PERF_EN
  localparam int OW = $clog2(DEPTH + 1);

  logic          out_ack_q;
  logic          ack_tgl;
  logic [OW-1:0] occ_q;
  logic [15:0]   tok_cnt_q;

  assign ack_tgl = bus.out_ack ^ out_ack_q;

  // Accept and deliver in the same edge cancel; occupancy saturates at both ends.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_ack_q <= 1'b0;
      occ_q     <= '0;
      tok_cnt_q <= '0;
    end else begin
      out_ack_q <= bus.out_ack;
      if (fire[0] && !ack_tgl && occ_q != OW'(DEPTH)) begin
        occ_q <= occ_q + OW'(1);
      end else if (!fire[0] && ack_tgl && occ_q != '0) begin
        occ_q <= occ_q - OW'(1);
      end
      if (ack_tgl) begin
        tok_cnt_q <= tok_cnt_q + 16'd1;
      end
    end
  end

  assign occ     = occ_q;
  assign tok_cnt = tok_cnt_q;
`else
  // Handshake-only build: no occupancy or delivery counters.
`endif
endmodule

// File: tb/tb_muller_c_join_pipe.sv
// Directed scoreboard bench for muller_c_join_pipe (NCHAN=2, WIDTH=4, DEPTH=3).
// Counter checks are compiled in only when MULLER_C_PERF_EN is defined.
module tb_muller_c_join_pipe;
  localparam int NCHAN = 2;
  localparam int WIDTH = 4;
  localparam int DEPTH = 3;
  localparam int DW    = NCHAN * WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  muller_c_join_pipe_if #(.NCHAN(NCHAN), .WIDTH(WIDTH)) bus ();

`ifdef MULLER_C_PERF_EN
  logic [$clog2(DEPTH+1)-1:0] occ;
  logic [15:0]                tok_cnt;
`endif

  muller_c_join_pipe #(.NCHAN(NCHAN), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
`ifdef MULLER_C_PERF_EN
    ,
    .occ      (occ),
    .tok_cnt  (tok_cnt)
`endif
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb [$];
  logic          phase;
  logic [15:0]   ack_count;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic ack_out();
    bus.out_ack = bus.out_req;
    ack_count++;
  endtask

  task automatic take_token(input string tag, input int limit, input bit do_ack, output int edges);
    edges = 0;
    while (bus.out_req === bus.out_ack && edges < limit) begin
      tick();
      edges++;
    end
    check({tag, "_arrive"}, 32'(bus.out_req !== bus.out_ack), 32'd1);
    if (bus.out_req !== bus.out_ack) begin
      check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check({tag, "_data"}, 32'(bus.out_data), 32'(sb.pop_front()));
      if (do_ack) ack_out();
    end
  endtask

  task automatic send(input logic [DW-1:0] data, input int limit, output bit accepted);
    phase       = ~phase;
    bus.in_data = data;
    bus.in_req  = {NCHAN{phase}};
    sb.push_back(data);
    accepted = 1'b0;
    for (int k = 0; k < limit && !accepted; k++) begin
      tick();
      if (bus.in_ack === phase) accepted = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.in_req  = '0;
    bus.in_data = '0;
    bus.out_ack = 1'b0;
    tick();
    rst       = 1'b0;
    phase     = 1'b0;
    ack_count = '0;
    sb.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ack"},   32'(bus.in_ack),   32'd0);
    check({tag, "_out_req"},  32'(bus.out_req),  32'd0);
    check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
`ifdef MULLER_C_PERF_EN
    check({tag, "_occ"},     32'(occ),     32'd0);
    check({tag, "_tok_cnt"}, 32'(tok_cnt), 32'd0);
`endif
  endtask

  initial begin
    int            e;
    bit            acc;
    int            sent;
    int            got;
    logic [DW-1:0] data;

    bus.in_req  = '0;
    bus.in_data = '0;
    bus.out_ack = 1'b0;
    phase       = 1'b0;
    ack_count   = '0;
    rst         = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");

    // Single token: ack on edge 1, output request on edge 3.
    phase       = 1'b1;
    bus.in_data = 8'hA5;
    bus.in_req  = 2'b11;
    sb.push_back(8'hA5);
    tick();
    check("single_in_ack_e1", 32'(bus.in_ack), 32'd1);
    check("single_out_req_e1", 32'(bus.out_req), 32'd0);
`ifdef MULLER_C_PERF_EN
    check("single_occ_e1", 32'(occ), 32'd1);
`endif
    tick();
    check("single_out_req_e2", 32'(bus.out_req), 32'd0);
    tick();
    check("single_out_req_e3", 32'(bus.out_req), 32'd1);
    take_token("single", 0, 1'b1, e);
    tick();
`ifdef MULLER_C_PERF_EN
    check("single_occ_done", 32'(occ), 32'd0);
    check("single_tok_cnt", 32'(tok_cnt), 32'(ack_count));
`endif

    // Join skew: only channel 0 toggles, stage 0 must wait for channel 1.
    bus.in_data = 8'h3C;
    bus.in_req  = 2'b10;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("skew_hold", 32'(bus.in_ack), 32'd1);
    end
    phase       = 1'b0;
    bus.in_data = 8'h5A;
    bus.in_req  = 2'b00;
    sb.push_back(8'h5A);
    tick();
    check("skew_join_ack", 32'(bus.in_ack), 32'd0);
    take_token("skew", 5, 1'b1, e);
    check("skew_latency", 32'(e), 32'd2);

    // Fill and stall with the consumer idle.
    send(8'h11, 4, acc);
    check("fill_acc_11", 32'(acc), 32'd1);
    send(8'h22, 4, acc);
    check("fill_acc_22", 32'(acc), 32'd1);
    send(8'h33, 4, acc);
    check("fill_acc_33", 32'(acc), 32'd1);
`ifdef MULLER_C_PERF_EN
    check("fill_occ_full", 32'(occ), 32'd3);
`endif
    send(8'h44, 6, acc);
    check("fill_stall_44", 32'(acc), 32'd0);
    check("fill_in_ack_held", 32'(bus.in_ack), 32'd1);
`ifdef MULLER_C_PERF_EN
    check("fill_occ_stall", 32'(occ), 32'd3);
`endif
    take_token("fill_11", 0, 1'b1, e);
    tick();
    take_token("fill_22", 0, 1'b0, e);
    tick();
    tick();
    check("fill_44_acked", 32'(bus.in_ack), 32'(phase));
    ack_out();
    take_token("fill_33", 6, 1'b1, e);
    take_token("fill_44", 6, 1'b1, e);
    tick();
    check("fill_drained", 32'(sb.size()), 32'd0);
`ifdef MULLER_C_PERF_EN
    check("fill_occ_empty", 32'(occ), 32'd0);
    check("fill_tok_cnt", 32'(tok_cnt), 32'(ack_count));
`endif

    // Reset with two tokens held, then a fresh token must pass normally.
    send(8'h77, 4, acc);
    check("midrst_acc_77", 32'(acc), 32'd1);
    send(8'h88, 4, acc);
    check("midrst_acc_88", 32'(acc), 32'd1);
    tick();
    tick();
    check("midrst_holding", 32'(bus.out_req), 32'd1);
    do_reset();
    check_idle("midrst");
    send(8'h99, 2, acc);
    check("fresh_acc", 32'(acc), 32'd1);
    take_token("fresh", 5, 1'b1, e);
    check("fresh_latency", 32'(e), 32'd2);

    // Streaming: consumer echoes out_req every edge over 64 random tokens.
    do_reset();
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 2000 && got < 64; cyc++) begin
      if (bus.out_req !== bus.out_ack) begin
        check("stream_sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("stream_data", 32'(bus.out_data), 32'(sb.pop_front()));
        ack_out();
        got++;
      end
      if (sent < 64 && bus.in_ack === phase) begin
        phase       = ~phase;
        data        = DW'($urandom_range(0, 255));
        bus.in_data = data;
        bus.in_req  = {NCHAN{phase}};
        sb.push_back(data);
        sent++;
      end
      tick();
    end
    check("stream_delivered", 32'(got), 32'd64);
    check("stream_sb_empty", 32'(sb.size()), 32'd0);
`ifdef MULLER_C_PERF_EN
    check("stream_tok_cnt", 32'(tok_cnt), 32'd64);
    check("stream_occ", 32'(occ), 32'd0);

    // Delivery counter wraps from FFFF to 0.
    force dut.tok_cnt_q = 16'hFFFF;
    tick();
    release dut.tok_cnt_q;
    ack_count = 16'hFFFF;
    send(8'h5E, 2, acc);
    check("wrap_acc", 32'(acc), 32'd1);
    take_token("wrap", 5, 1'b1, e);
    tick();
    check("wrap_tok_cnt", 32'(tok_cnt), 32'd0);
    check("wrap_model", 32'(ack_count), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
